// File: rtl/vga_sync_receiver_if.sv
// Link-side bundle for the VGA sync receiver.
// master drives syncs and colour and observes the recovered timing; slave is the receiver.
interface vga_sync_receiver_if;
    logic       hSync;
    logic       vSync;
    logic [2:0] colorIn;
    logic       locked;
    logic       pixelValid;
    logic [8:0] row;
    logic [9:0] column;
    logic [2:0] pixelColor;
    logic       frameStart;
    logic       hErr;
    logic       vErr;
    logic [7:0] errCount;

    modport master (
        output hSync, vSync, colorIn,
        input  locked, pixelValid, row, column, pixelColor,
        input  frameStart, hErr, vErr, errCount
    );

    modport slave (
        input  hSync, vSync, colorIn,
        output locked, pixelValid, row, column, pixelColor,
        output frameStart, hErr, vErr, errCount
    );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers row/column of visible pixels from hSync/vSync/colour
// and checks line and frame periods, locking only after consistent timing.
module vga_sync_receiver #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    vga_sync_receiver_if.slave bus
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_START  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END    = 11'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [10:0] V_START  = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_END    = 11'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [10:0] TIMEOUT  = 11'(2 * H_TOTAL - 1);
    localparam logic [10:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        SEARCH,
        H_OK,
        LOCKED
    } state_t;

    state_t      state, state_nx;

    logic        hs_r, hs_p, vs_r, vs_p;
    logic [2:0]  col_r, col2;
    logic [10:0] hCount, vCount;
    logic        anchor_f;
    logic        have_prev, have_prev_nx;
    logic [1:0]  good_cnt, good_nx;
    logic        measuring, meas_nx;
    logic        herr2, herr_nx;
    logic        verr2, verr_nx;
    logic        fs2, fs_nx;

    logic        h_edge, v_edge, frame_anchor, line_ok, frame_ok, timeout;
    logic        in_win, valid;

    assign h_edge       = (hs_r == SYNC_POL) && (hs_p != SYNC_POL);
    assign v_edge       = (vs_r == SYNC_POL) && (vs_p != SYNC_POL);
    // A pending vSync (or one arriving now) is resolved at the next line start,
    // so mid-line and line-start vSync produce the same line numbering.
    assign frame_anchor = h_edge && (anchor_f || v_edge);
    assign line_ok      = (hCount == H_LAST);
    assign frame_ok     = (vCount == V_LAST);
    assign timeout      = (state != SEARCH) && !h_edge && (hCount == TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_r  <= 1'b0;
            hs_p  <= 1'b0;
            vs_r  <= 1'b0;
            vs_p  <= 1'b0;
            col_r <= '0;
        end else begin
            hs_r  <= bus.hSync;
            hs_p  <= hs_r;
            vs_r  <= bus.vSync;
            vs_p  <= vs_r;
            col_r <= bus.colorIn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col2     <= '0;
            hCount   <= '0;
            vCount   <= '0;
            anchor_f <= 1'b0;
        end else begin
            col2 <= col_r;
            if (h_edge)
                hCount <= '0;
            else if (hCount != CNT_MAX)
                hCount <= hCount + 11'd1;

            if (frame_anchor)
                vCount <= '0;
            else if (h_edge && vCount != CNT_MAX)
                vCount <= vCount + 11'd1;

            if (frame_anchor)
                anchor_f <= 1'b0;
            else if (v_edge)
                anchor_f <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            have_prev <= 1'b0;
            good_cnt  <= '0;
            measuring <= 1'b0;
            herr2     <= 1'b0;
            verr2     <= 1'b0;
            fs2       <= 1'b0;
        end else begin
            state     <= state_nx;
            have_prev <= have_prev_nx;
            good_cnt  <= good_nx;
            measuring <= meas_nx;
            herr2     <= herr_nx;
            verr2     <= verr_nx;
            fs2       <= fs_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        have_prev_nx = have_prev;
        good_nx      = good_cnt;
        meas_nx      = measuring;
        herr_nx      = 1'b0;
        verr_nx      = 1'b0;
        fs_nx        = 1'b0;

        case (state)
            SEARCH: begin
                if (h_edge) begin
                    if (!have_prev) begin
                        have_prev_nx = 1'b1;
                    end else if (line_ok) begin
                        if (good_cnt == 2'd1) begin
                            state_nx = H_OK;
                            good_nx  = '0;
                            meas_nx  = 1'b0;
                        end else begin
                            good_nx = good_cnt + 2'd1;
                        end
                    end else begin
                        good_nx = '0;
                    end
                end
            end
            H_OK: begin
                if (frame_anchor) begin
                    if (!measuring)
                        meas_nx = 1'b1;
                    else if (frame_ok)
                        state_nx = LOCKED;
                    else
                        verr_nx = 1'b1;
                end
            end
            LOCKED: begin
                if (frame_anchor) begin
                    if (frame_ok) begin
                        fs_nx = 1'b1;
                    end else begin
                        verr_nx  = 1'b1;
                        state_nx = H_OK;
                        meas_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = SEARCH;
        endcase

        // Line-period failures override any frame decision taken above.
        if ((state != SEARCH) && ((h_edge && !line_ok) || timeout)) begin
            herr_nx      = 1'b1;
            fs_nx        = 1'b0;
            state_nx     = SEARCH;
            have_prev_nx = 1'b0;
            good_nx      = '0;
        end
    end

    assign in_win = (hCount >= H_START) && (hCount < H_END) &&
                    (vCount >= V_START) && (vCount < V_END);
    assign valid  = (state == LOCKED) && in_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.locked     <= 1'b0;
            bus.pixelValid <= 1'b0;
            bus.row        <= '0;
            bus.column     <= '0;
            bus.pixelColor <= '0;
            bus.frameStart <= 1'b0;
            bus.hErr       <= 1'b0;
            bus.vErr       <= 1'b0;
            bus.errCount   <= '0;
        end else begin
            bus.locked     <= (state == LOCKED);
            bus.pixelValid <= valid;
            bus.row        <= valid ? 9'(vCount - V_START) : '0;
            bus.column     <= valid ? 10'(hCount - H_START) : '0;
            bus.pixelColor <= valid ? col2 : '0;
            bus.frameStart <= fs2;
            bus.hErr       <= herr2;
            bus.vErr       <= verr2;
            if ((herr2 || verr2) && (bus.errCount != '1))
                bus.errCount <= bus.errCount + 8'd1;
        end
    end
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on scaled-down timing; a generator pushes
// expected pixels into a scoreboard that a negedge monitor pops and compares.
module tb_vga_sync_receiver;
    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
    localparam int H_TOTAL = HV + HF + HS + HB;
    localparam int V_TOTAL = VV + VF + VS + VB;
    localparam int HSTART  = HS + HB;
    localparam int VSTART  = VS + VB;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam int NPIX    = HV * VV;
    localparam int SHIFT   = H_TOTAL / 2;
    localparam int RST_H   = 10;

    typedef struct {
        logic [21:0] px;
        int          t;
    } exp_t;

    logic clk, rst;
    vga_sync_receiver_if bus ();

    vga_sync_receiver #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   cyc = 0;
    int   n_checks = 0, n_fail = 0;
    int   n_pix = 0, n_herr = 0, n_verr = 0, n_fs = 0;
    int   last_herr_cyc = -1, last_verr_cyc = -1, lock_rise_cyc = -1;
    int   anchor_cyc = -1, last_hedge_cyc = -1;
    int   exp_err = 0;
    exp_t q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_locked"},     32'(bus.locked),     0);
        check({tag, "_pixelValid"}, 32'(bus.pixelValid), 0);
        check({tag, "_row"},        32'(bus.row),        0);
        check({tag, "_column"},     32'(bus.column),     0);
        check({tag, "_pixelColor"}, 32'(bus.pixelColor), 0);
        check({tag, "_frameStart"}, 32'(bus.frameStart), 0);
        check({tag, "_hErr"},       32'(bus.hErr),       0);
        check({tag, "_vErr"},       32'(bus.vErr),       0);
        check({tag, "_errCount"},   32'(bus.errCount),   0);
    endtask

    // Drives lines first_line..nlines-1; short_line is one clock short, vshift moves
    // the vSync assertion to mid-line of the previous line, push_lim limits expectations.
    task automatic run_frame(input int first_line, input int nlines, input int short_line,
                             input bit vshift, input int push_lim, input int rst_line);
        for (int v = first_line; v < nlines; v++) begin
            for (int h = 0; h < ((v == short_line) ? H_TOTAL - 1 : H_TOTAL); h++) begin
                logic       vs_a;
                logic [2:0] c;
                int         cx;
                @(posedge clk);
                #1;
                if (v == 0 && h == 0) anchor_cyc = cyc;
                if (h == 0) last_hedge_cyc = cyc;
                if (vshift)
                    vs_a = (v < VS - 1) || (v == VS - 1 && h < SHIFT) || (v == nlines - 1 && h >= SHIFT);
                else
                    vs_a = (v < VS);
                cx = h - HSTART;
                c  = cx[2:0];
                bus.hSync   = (h < HS) ? 1'b0 : 1'b1;
                bus.vSync   = vs_a ? 1'b0 : 1'b1;
                bus.colorIn = c;
                if (v >= VSTART && v < VSTART + VV && h >= HSTART && h < HSTART + HV && v < push_lim)
                    q.push_back('{px: {9'(v - VSTART), 10'(h - HSTART), c}, t: cyc});
                if (v == rst_line && h == RST_H + 2) rst = 1'b0;
                if (v == rst_line && h == RST_H) begin
                    #2 rst = 1'b1;
                    #1 check_zero("async_rst");
                end
            end
        end
    endtask

    initial begin
        int pix_in_frame = 0, last_fs = -1, pix_before;
        bit prev_locked = 1'b0;
        exp_t e;

        rst = 1'b1;
        bus.hSync = 1'b1;
        bus.vSync = 1'b1;
        bus.colorIn = '0;

        fork
            forever begin
                @(negedge clk);
                if (bus.pixelValid === 1'b1) begin
                    n_pix++;
                    pix_in_frame++;
                    check("pix_pending", 32'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("pix_value", {10'd0, bus.row, bus.column, bus.pixelColor}, {10'd0, e.px});
                        check("pix_latency", cyc, e.t + 3);
                    end
                end
                if (bus.hErr === 1'b1) begin n_herr++; last_herr_cyc = cyc; end
                if (bus.vErr === 1'b1) begin n_verr++; last_verr_cyc = cyc; end
                if (bus.frameStart === 1'b1) begin
                    n_fs++;
                    if (last_fs >= 0) check("fs_interval", cyc - last_fs, FRAME);
                    check("frame_pixels", pix_in_frame, NPIX);
                    last_fs = cyc;
                    pix_in_frame = 0;
                end
                if (bus.locked !== 1'b1) begin last_fs = -1; pix_in_frame = 0; end
                if (bus.locked === 1'b1 && !prev_locked) lock_rise_cyc = cyc;
                prev_locked = (bus.locked === 1'b1);
            end
        join_none

        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Initial lock: start mid-frame, lock expected at the second anchor.
        run_frame(7, V_TOTAL, -1, 1'b0, 0, -1);
        run_frame(0, V_TOTAL, -1, 1'b0, 0, -1);
        check("lock_after_f1", 32'(bus.locked), 0);
        run_frame(0, V_TOTAL, -1, 1'b0, V_TOTAL, -1);
        check("lock_rise_f2", lock_rise_cyc, anchor_cyc + 3);
        check("locked_f2", 32'(bus.locked), 1);
        run_frame(0, V_TOTAL, -1, 1'b0, V_TOTAL, -1);
        run_frame(0, V_TOTAL, -1, 1'b0, V_TOTAL, -1);
        check("fs_count", n_fs, 2);
        check("errs_clean", 32'(bus.errCount), 0);

        // One short line at line 7 while locked.
        run_frame(0, V_TOTAL, 7, 1'b0, 8, -1);
        exp_err++;
        check("short_line_herr_n", n_herr, 1);
        check("short_line_herr_t", last_herr_cyc, anchor_cyc + 7 * H_TOTAL + (H_TOTAL - 1) + 3);
        check("short_line_unlock", 32'(bus.locked), 0);
        check("short_line_errcnt", 32'(bus.errCount), exp_err);
        run_frame(0, V_TOTAL, -1, 1'b0, 0, -1);
        check("short_line_relock_a", 32'(bus.locked), 0);
        run_frame(0, V_TOTAL, -1, 1'b0, V_TOTAL, -1);
        check("short_line_relock_t", lock_rise_cyc, anchor_cyc + 3);
        check("short_line_errcnt2", 32'(bus.errCount), exp_err);

        // One frame with a missing line while locked.
        run_frame(0, V_TOTAL - 1, -1, 1'b0, V_TOTAL, -1);
        run_frame(0, V_TOTAL, -1, 1'b0, 0, -1);
        exp_err++;
        check("short_frame_verr_n", n_verr, 1);
        check("short_frame_verr_t", last_verr_cyc, anchor_cyc + 3);
        check("short_frame_no_herr", n_herr, 1);
        check("short_frame_unlock", 32'(bus.locked), 0);
        check("short_frame_errcnt", 32'(bus.errCount), exp_err);
        run_frame(0, V_TOTAL, -1, 1'b0, V_TOTAL, -1);
        check("short_frame_relock_t", lock_rise_cyc, anchor_cyc + 3);

        // vSync moved to mid-line of the previous line, then back.
        run_frame(0, V_TOTAL, -1, 1'b1, V_TOTAL, -1);
        run_frame(0, V_TOTAL, -1, 1'b1, V_TOTAL, -1);
        run_frame(0, V_TOTAL, -1, 1'b0, V_TOTAL, -1);
        run_frame(0, V_TOTAL, -1, 1'b0, V_TOTAL, -1);
        check("vshift_no_verr", n_verr, 1);
        check("vshift_no_herr", n_herr, 1);
        check("vshift_locked", 32'(bus.locked), 1);

        // hSync stuck deasserted after one blank line.
        run_frame(0, 1, -1, 1'b0, 0, -1);
        pix_before = n_pix;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            bus.hSync = 1'b1;
            bus.vSync = 1'b1;
        end
        exp_err++;
        check("stuck_herr_n", n_herr, 2);
        check("stuck_herr_t", last_herr_cyc, last_hedge_cyc + 2 * H_TOTAL + 3);
        check("stuck_no_pix", n_pix, pix_before);
        check("stuck_unlock", 32'(bus.locked), 0);
        check("stuck_errcnt", 32'(bus.errCount), exp_err);
        run_frame(0, V_TOTAL, -1, 1'b0, 0, -1);
        run_frame(0, V_TOTAL, -1, 1'b0, 0, -1);
        run_frame(0, V_TOTAL, -1, 1'b0, V_TOTAL, -1);
        check("stuck_relock_t", lock_rise_cyc, anchor_cyc + 3);

        // Asynchronous reset at visible row 4.
        run_frame(0, V_TOTAL, -1, 1'b0, VSTART + 4, VSTART + 4);
        exp_err = 0;
        run_frame(0, V_TOTAL, -1, 1'b0, 0, -1);
        check("rst_relock_a", 32'(bus.locked), 0);
        run_frame(0, V_TOTAL, -1, 1'b0, V_TOTAL, -1);
        check("rst_relock_t", lock_rise_cyc, anchor_cyc + 3);
        check("rst_errcnt", 32'(bus.errCount), exp_err);
        check("rst_no_herr", n_herr, 2);
        check("rst_no_verr", n_verr, 1);

        repeat (5) @(posedge clk);
        #1 check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
